// File: rtl/pcpi_arb_pkg.sv
// Shared types and decode helpers for the PCPI mul/div arbiter.
// Used by pcpi_muldiv_arbiter and pcpi_rr_pick.
package pcpi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP32      = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic is_muldiv(input logic [31:0] insn);
    logic opc_ok;
    opc_ok = (insn[6:0] == OPC_OP) || (insn[6:0] == OPC_OP32);
    return opc_ok && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/pcpi_rr_pick.sv
// Combinational round-robin picker: first eligible index
// at or after ptr, wrapping modulo NREQ.
import pcpi_arb_pkg::*;

module pcpi_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any_grant
);

  always_comb begin
    int j;
    idx       = '0;
    any_grant = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any_grant && elig[j[IW-1:0]]) begin
        any_grant = 1'b1;
        idx       = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pcpi_muldiv_arbiter.sv
// Shares one PCPI mul/div unit pair between NREQ cores.
// Optional PCPI_ARB_TIMEOUT_EN adds a forced error response.
import pcpi_arb_pkg::*;

module pcpi_muldiv_arbiter #(
  parameter int XLEN    = 64,
  parameter int NREQ    = 2,
  parameter int RECOVER = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_insn,
  input  logic [NREQ*XLEN-1:0] req_rs1,
  input  logic [NREQ*XLEN-1:0] req_rs2,
  output logic [NREQ-1:0]      req_ready,
  output logic                 req_wr,
  output logic [XLEN-1:0]      req_rd,
  output logic                 req_err,
  output logic                 unit_valid,
  output logic [31:0]          unit_insn,
  output logic [XLEN-1:0]      unit_rs1,
  output logic [XLEN-1:0]      unit_rs2,
  input  logic                 unit_ready,
  input  logic                 unit_wr,
  input  logic [XLEN-1:0]      unit_rd
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (TIMEOUT > RECOVER) ? TIMEOUT : RECOVER;
  localparam int CW   = (MAXC < 255) ? 8 : $clog2(MAXC + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       insn_q, insn_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic              wr_q, wr_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   elig;
  logic [IW-1:0]     pick;
  logic              any;
`ifdef PCPI_ARB_TIMEOUT_EN
  logic              err_q, err_d;
`endif

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && is_muldiv(req_insn[32*i +: 32]);
  end

  pcpi_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .elig      (elig),
    .ptr       (rr_q),
    .idx       (pick),
    .any_grant (any)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef PCPI_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
`ifdef PCPI_ARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
`ifdef PCPI_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any) begin
          idx_d = pick;
          for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == pick) begin
              insn_d = req_insn[32*i +: 32];
              rs1_d  = req_rs1[XLEN*i +: XLEN];
              rs2_d  = req_rs2[XLEN*i +: XLEN];
            end
          end
          rr_d    = (int'(pick) == NREQ - 1) ? '0 : pick + IW'(1);
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (unit_ready) begin
          wr_d    = unit_wr;
          rd_d    = unit_rd;
`ifdef PCPI_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
`ifdef PCPI_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          wr_d    = 1'b0;
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = (RECOVER == 0) ? IDLE : pcpi_arb_pkg::RECOVER;
      end
      pcpi_arb_pkg::RECOVER: begin
        if (cnt_q == CW'(RECOVER - 1))
          state_d = IDLE;
        else
          cnt_d = cnt_q + CW'(1);
      end
    endcase
  end

  always_comb begin
    unit_valid = 1'b0;
    req_ready  = '0;
    req_wr     = 1'b0;
    unique case (state_q)
      ISSUE: unit_valid = 1'b1;
      RESP: begin
        req_ready[idx_q] = 1'b1;
        req_wr           = wr_q;
      end
      default: ;
    endcase
  end

  assign unit_insn = insn_q;
  assign unit_rs1  = rs1_q;
  assign unit_rs2  = rs2_q;
  assign req_rd    = rd_q;
`ifdef PCPI_ARB_TIMEOUT_EN
  assign req_err   = err_q;
`else
  assign req_err   = 1'b0;
`endif

endmodule
